// File: rtl/cga_text_sequencer.sv
// ---------------------------------------------------------------------------
// cga_text_sequencer
//
// Text-mode pixel sequencer sitting directly behind the CRTC. A 3-bit slot
// counter divides the dot rate by eight. It drives the CRTC character enable
// and fetches the character/attribute byte pair from VRAM, then the glyph row
// from the font ROM. It shifts out 4-bit IRGB pixels with blink and cursor
// handling applied.
//
// The pipeline is two characters deep. Everything fetched during character
// period N is loaded into the output shifter on the char_en that closes
// period N, so it is displayed during period N+1.
//
// Fetch schedule (each action happens on the pix_en that enters the slot):
//   slot 0 : vram_addr <= char byte address, vram_rd pulse
//   slot 2 : char_lat <= vram_data; vram_addr <= attr byte address, vram_rd
//   slot 4 : attr_lat <= vram_data; font_addr <= {char, row}; sample de/cursor
//   slot 6 : font_lat <= font_data
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   pix_en          one pulse per dot; all state holds while low
//   char_en         pix_en & (slot == 7), combinational, to the CRTC divider
//   mem_addr        CRTC character index
//   row_addr        CRTC scanline within the character row
//   display_enable  CRTC active-display flag
//   cursor          CRTC cursor flag, already blink-gated
//   vram_addr       VRAM byte address (even = char, odd = attr), registered
//   vram_rd         one-clk VRAM read strobe
//   vram_data       VRAM read data, valid within 2 pix_en of vram_rd
//   font_addr       font ROM address {char code, row}, registered
//   font_data       font ROM data, bit 7 = leftmost dot
//   blink_en        1: attr bit 7 is blink; 0: attr bit 7 is bright background
//   blink_phase     slow blink toggle, 0 hides blinking characters
//   border_color    IRGB colour used outside the active display
//   pixel           IRGB pixel, registered, changes only on pix_en
// ---------------------------------------------------------------------------
module cga_text_sequencer #(
    parameter int VRAM_AW = 14,
    parameter int FONT_AW = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic               char_en,
    input  logic [13:0]        mem_addr,
    input  logic [4:0]         row_addr,
    input  logic               display_enable,
    input  logic               cursor,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_rd,
    input  logic [7:0]         vram_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic               blink_en,
    input  logic               blink_phase,
    input  logic [3:0]         border_color,
    output logic [3:0]         pixel
);

    // Slot values seen just before the pix_en that enters slots 0/2/4/6.
    localparam logic [2:0] SLOT_PRE_CHAR = 3'd7;
    localparam logic [2:0] SLOT_PRE_ATTR = 3'd1;
    localparam logic [2:0] SLOT_PRE_FONT = 3'd3;
    localparam logic [2:0] SLOT_PRE_GLYPH = 3'd5;

    logic [2:0] slot;

    // Fetch stage (character being fetched this period).
    logic [7:0] char_lat;
    logic [7:0] attr_lat;
    logic [7:0] font_lat;
    logic       de_s;
    logic       cur_s;

    // Display stage (character being shifted out this period).
    logic [7:0] shift;
    logic [7:0] attr_o;
    logic       de_o;
    logic       cur_o;

    // Next-state values for the display stage and the pixel register.
    logic [7:0] shift_nxt;
    logic [7:0] attr_nxt;
    logic       de_nxt;
    logic       cur_nxt;
    logic [3:0] fg;
    logic [3:0] bg;
    logic       hidden;
    logic       dot_on;
    logic [3:0] pixel_nxt;

    // Upper address bits are dropped on purpose: character addressing wraps
    // modulo the VRAM size and never carries into the char/attr select bit.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[13:VRAM_AW-1], row_addr[4:FONT_AW-8]};

    assign char_en = pix_en & (slot == SLOT_PRE_CHAR);

    // The pixel register captures the colour of the dot that the shifter
    // presents after this pix_en. On char_en that is dot 0 of the freshly
    // loaded character, so the colour is computed from next-state values.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        shift_nxt = {shift[6:0], 1'b0};
        attr_nxt  = attr_o;
        de_nxt    = de_o;
        cur_nxt   = cur_o;
        if (char_en) begin
            shift_nxt = font_lat;
            attr_nxt  = attr_lat;
            de_nxt    = de_s;
            cur_nxt   = cur_s;
        end

        fg     = attr_nxt[3:0];
        bg     = {blink_en ? 1'b0 : attr_nxt[7], attr_nxt[6:4]};
        hidden = blink_en & attr_nxt[7] & ~blink_phase;
        dot_on = cur_nxt | (shift_nxt[7] & ~hidden);

        pixel_nxt = border_color;
        if (de_nxt) begin
            pixel_nxt = dot_on ? fg : bg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot      <= '0;
            vram_addr <= '0;
            vram_rd   <= 1'b0;
            font_addr <= '0;
            char_lat  <= '0;
            attr_lat  <= '0;
            font_lat  <= '0;
            de_s      <= 1'b0;
            cur_s     <= 1'b0;
            shift     <= '0;
            attr_o    <= '0;
            de_o      <= 1'b0;
            cur_o     <= 1'b0;
            pixel     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            vram_rd <= 1'b0;
            if (pix_en) begin
                slot   <= slot + 3'd1;
                shift  <= shift_nxt;
                attr_o <= attr_nxt;
                de_o   <= de_nxt;
                cur_o  <= cur_nxt;
                pixel  <= pixel_nxt;

                case (slot)
                    SLOT_PRE_CHAR: begin
                        vram_addr <= {mem_addr[VRAM_AW-2:0], 1'b0};
                        vram_rd   <= 1'b1;
                    end
                    SLOT_PRE_ATTR: begin
                        char_lat  <= vram_data;
                        vram_addr <= {mem_addr[VRAM_AW-2:0], 1'b1};
                        vram_rd   <= 1'b1;
                    end
                    SLOT_PRE_FONT: begin
                        attr_lat  <= vram_data;
                        font_addr <= {char_lat, row_addr[FONT_AW-9:0]};
                        de_s      <= display_enable;
                        cur_s     <= cursor;
                    end
                    SLOT_PRE_GLYPH: begin
                        font_lat <= font_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cga_text_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cga_text_sequencer
//
// Directed bench for cga_text_sequencer with VRAM and font ROM models.
// When the bench drives a character fetch (at the slot-4 sampling edge), it
// builds the expected character record from its own VRAM/font arrays and
// pushes it onto a scoreboard queue. The record is popped when the DUT loads
// its shifter (char_en), and every pixel of the following period is compared
// against the colour computed from that record. Selected characters are also
// captured and compared against hand-written dot sequences.
// ---------------------------------------------------------------------------
module tb_cga_text_sequencer;

    localparam int VRAM_AW = 14;
    localparam int FONT_AW = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic               pix_en;
    logic               char_en;
    logic [13:0]        mem_addr;
    logic [4:0]         row_addr;
    logic               display_enable;
    logic               cursor;
    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_rd;
    logic [7:0]         vram_data = '0;
    logic [FONT_AW-1:0] font_addr;
    logic [7:0]         font_data = '0;
    logic               blink_en;
    logic               blink_phase;
    logic [3:0]         border_color;
    logic [3:0]         pixel;

    always #5 clk = ~clk;

    cga_text_sequencer #(
        .VRAM_AW(VRAM_AW),
        .FONT_AW(FONT_AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_en         (pix_en),
        .char_en        (char_en),
        .mem_addr       (mem_addr),
        .row_addr       (row_addr),
        .display_enable (display_enable),
        .cursor         (cursor),
        .vram_addr      (vram_addr),
        .vram_rd        (vram_rd),
        .vram_data      (vram_data),
        .font_addr      (font_addr),
        .font_data      (font_data),
        .blink_en       (blink_en),
        .blink_phase    (blink_phase),
        .border_color   (border_color),
        .pixel          (pixel)
    );

    // Memory models: one-clk read latency, well inside the 2-pix_en window.
    logic [7:0] vram [0:16383];
    logic [7:0] font [0:4095];

    always @(posedge clk) begin
        if (vram_rd) vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    // Scoreboard
    typedef struct packed {
        logic [7:0] glyph;
        logic [7:0] attr;
        logic       de;
        logic       cur;
    } rec_t;

    rec_t q[$];
    rec_t disp;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side pipeline tracking
    int          b_slot;
    logic [13:0] f_addr;
    logic [13:0] nx_addr;
    logic [4:0]  p_row;
    logic        p_de;
    logic        p_c3;
    logic        p_c5;
    bit          first_period;
    logic [7:0]  m_shift;
    logic [3:0]  exp_pix;
    logic [13:0] exp_vaddr;
    logic [11:0] exp_faddr;
    bit          faddr_known;
    int          idle_max;
    logic [3:0]  cap [8];
    logic [3:0]  last_cap [8];
    int          cap_n;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_color(input logic dot, input rec_t r, input logic ben,
                                             input logic bph, input logic [3:0] bc);
        logic [3:0] fg;
        logic [3:0] bg;
        logic       hid;
        logic       on;
        fg  = r.attr[3:0];
        bg  = {ben ? 1'b0 : r.attr[7], r.attr[6:4]};
        hid = ben & r.attr[7] & ~bph;
        on  = r.cur | (dot & ~hid);
        if (!r.de) return bc;
        return on ? fg : bg;
    endfunction

    task automatic model_reset();
        q.delete();
        disp         = '0;
        b_slot       = 0;
        f_addr       = '0;
        first_period = 1'b1;
        m_shift      = '0;
        exp_pix      = '0;
        exp_vaddr    = '0;
        exp_faddr    = '0;
        faddr_known  = 1'b1;
        cap_n        = 0;
    endtask

    // One clock: drive inputs for the coming edge, check char_en, clock,
    // advance the model and compare the registered outputs.
    task automatic step(input logic pe);
        logic [7:0] code;
        logic [7:0] attr;
        logic       exp_rd;
        pix_en = pe;
        if (pe) begin
            mem_addr = (b_slot == 1) ? f_addr : (b_slot == 7) ? nx_addr : ~f_addr;
            row_addr = (b_slot == 3) ? p_row : ~p_row;
            cursor   = (b_slot == 3 && p_c3) || (b_slot == 5 && p_c5);
        end else begin
            mem_addr = 14'($urandom);
            row_addr = 5'($urandom);
            cursor   = 1'($urandom);
        end
        display_enable = (pe && b_slot == 3) ? p_de : ~p_de;
        #1;
        check("char_en", 16'(char_en), 16'(pe && b_slot == 7));
        @(posedge clk);
        #1;
        exp_rd = 1'b0;
        if (pe) begin
            case (b_slot)
                7: begin
                    exp_rd    = 1'b1;
                    exp_vaddr = {nx_addr[12:0], 1'b0};
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $error("FAIL scoreboard: observed empty queue expected a record");
                        disp = '0;
                    end else begin
                        disp = q.pop_front();
                    end
                    m_shift      = disp.glyph;
                    f_addr       = nx_addr;
                    first_period = 1'b0;
                    if (cap_n == 8) last_cap = cap;
                    cap_n = 0;
                end
                1: begin
                    exp_rd    = 1'b1;
                    exp_vaddr = {f_addr[12:0], 1'b1};
                end
                3: begin
                    code = vram[{f_addr[12:0], 1'b0}];
                    attr = vram[{f_addr[12:0], 1'b1}];
                    q.push_back('{glyph: font[{code, p_row[3:0]}], attr: attr, de: p_de, cur: p_c3});
                    exp_faddr   = {code, p_row[3:0]};
                    faddr_known = !first_period;
                end
                default: begin
                end
            endcase
            if (b_slot != 7) m_shift = {m_shift[6:0], 1'b0};
            exp_pix = exp_color(m_shift[7], disp, blink_en, blink_phase, border_color);
            if (cap_n < 8) begin
                cap[cap_n] = pixel;
                cap_n++;
            end
            b_slot = (b_slot + 1) % 8;
        end
        check("vram_rd", 16'(vram_rd), 16'(exp_rd));
        check("vram_addr", 16'(vram_addr), 16'(exp_vaddr));
        if (faddr_known) check("font_addr", 16'(font_addr), 16'(exp_faddr));
        check("pixel", 16'(pixel), 16'(exp_pix));
    endtask

    // One character period starting at slot 0. nx is the address fetched in
    // the next period; row/de/c3/c5 belong to the character fetched now; the
    // blink/border inputs take effect from this period's char_en onwards.
    task automatic run_period(input logic [13:0] nx, input logic [4:0] row, input logic de,
                              input logic c3, input logic c5, input logic ben,
                              input logic bph, input logic [3:0] bc);
        int n_idle;
        nx_addr = nx;
        p_row   = row;
        p_de    = de;
        p_c3    = c3;
        p_c5    = c5;
        for (int s = 0; s < 8; s++) begin
            if (s == 7) begin
                blink_en     = ben;
                blink_phase  = bph;
                border_color = bc;
            end
            n_idle = (idle_max > 0) ? int'($urandom_range(0, idle_max)) : 0;
            repeat (n_idle) step(1'b0);
            step(1'b1);
        end
    endtask

    // Dots of the most recently completed character, dot 0 in [31:28].
    task automatic check_cap(input string tag, input logic [31:0] gold);
        for (int i = 0; i < 8; i++) begin
            check(tag, 16'(last_cap[i]), 16'(gold[31-4*i -: 4]));
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 4096; i++) font[i] = 8'(i * 13 + 5);
        vram[0]      = 8'h41;
        vram[1]      = 8'h1E;
        vram[14'h3FFE] = 8'h42;
        vram[14'h3FFF] = 8'h8F;
        vram[14'h0010] = 8'h20;
        vram[14'h0011] = 8'h07;
        font[{8'h41, 4'h0}] = 8'hC3;
        font[{8'h42, 4'h2}] = 8'h5A;
        for (int r = 0; r < 16; r++) font[{8'h20, 4'(r)}] = 8'h00;

        reset          = 1'b1;
        pix_en         = 1'b1;
        mem_addr       = '0;
        row_addr       = '0;
        display_enable = 1'b0;
        cursor         = 1'b0;
        blink_en       = 1'b0;
        blink_phase    = 1'b0;
        border_color   = 4'h3;
        idle_max       = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_pixel", 16'(pixel), 16'h0);
        check("reset_vram_rd", 16'(vram_rd), 16'h0);
        check("reset_vram_addr", 16'(vram_addr), 16'h0);
        check("reset_font_addr", 16'(font_addr), 16'h0);
        check("reset_char_en", 16'(char_en), 16'h0);
        reset = 1'b0;

        // Character 'A' at address 0, then border, blink, wrap and cursor.
        run_period(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
        run_period(14'h0100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
        run_period(14'h3FFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
        check_cap("char_A_dots", 32'hEE1111EE);
        run_period(14'h3FFF, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
        check_cap("border_dots", 32'h66666666);
        run_period(14'h3FFF, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
        check_cap("blink_hidden_dots", 32'h00000000);
        run_period(14'h2000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
        check_cap("blink_shown_dots", 32'h0F0FF0F0);
        run_period(14'h0008, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
        check_cap("bright_bg_dots", 32'h8F8FF8F8);
        run_period(14'h0008, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
        check_cap("wrap_char_A_dots", 32'hEE1111EE);
        run_period(14'h0123, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
        check_cap("cursor_dots", 32'h77777777);
        run_period(14'h0456, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
        check_cap("late_cursor_dots", 32'h00000000);

        // Random characters with irregular pix_en spacing.
        idle_max = 2;
        for (int k = 0; k < 12; k++) begin
            run_period(14'($urandom), 5'($urandom), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                       1'($urandom), 4'($urandom));
        end
        idle_max = 0;

        // Freeze mid-character for 20 clocks, then reset during slot 3.
        nx_addr = 14'h0000;
        p_row   = 5'd0;
        p_de    = 1'b1;
        p_c3    = 1'b0;
        p_c5    = 1'b0;
        step(1'b1);
        step(1'b1);
        repeat (20) step(1'b0);
        step(1'b1);
        pix_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_pixel", 16'(pixel), 16'h0);
        check("midreset_vram_rd", 16'(vram_rd), 16'h0);
        check("midreset_vram_addr", 16'(vram_addr), 16'h0);
        check("midreset_font_addr", 16'(font_addr), 16'h0);
        check("midreset_char_en", 16'(char_en), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        run_period(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        run_period(14'h0055, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        run_period(14'h0066, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        check_cap("post_reset_char_A_dots", 32'hEE1111EE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
